hilo_muldiv_unit: RTL and testbench
===================================

# hilo_muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the 5-stage MIPS pipeline. It sits in the EX stage beside the main ALU. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the ID/EX register and computes products and quotients over multiple cycles. It exposes HI/LO to the MFHI/MFLO path feeding EX/MEM, and raises Busy so the hazard logic stalls IF/ID and ID/EX until results are valid.

## Interface
- DATA_WIDTH, 32, operand/HI/LO width; iteration count equals DATA_WIDTH.
- Clk  in  1  clock; all state updates on rising edge.
- Rst  in  1  synchronous, active-high reset.
- Start  in  1  request; sampled only while Busy=0.
- Op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others reserved (ignored).
- A  in  DATA_WIDTH  rs operand (multiplicand/dividend/MTHI-MTLO source).
- B  in  DATA_WIDTH  rt operand (multiplier/divisor).
- Flush  in  1  abort in-flight operation (branch/jump squash of the issuing instruction).
- Busy  out  1  high while an operation is in flight.
- Done  out  1  one-cycle pulse when HI/LO receive a mult/div result.
- DivByZero  out  1  one-cycle pulse, coincident with Done, for DIV/DIVU with B=0.
- Hi  out  DATA_WIDTH  architectural HI.
- Lo  out  DATA_WIDTH  architectural LO.

## Operation
- Reset: Hi=0, Lo=0, Busy=0, Done=0, DivByZero=0, state IDLE.
- FSM states: IDLE, RUN, FINISH.
  - IDLE→RUN on Start with a mult/div Op.
  - RUN→FINISH after DATA_WIDTH iterations.
  - FINISH→IDLE unconditionally.
  - Any state→IDLE on Flush.
- On accept, latch Op, latch the sign flags, and latch the magnitudes |A| and |B| (signed ops) or A and B (unsigned ops). Iteration counter starts at 0.
- Multiply: shift-add, one multiplier bit per cycle, into a 2×DATA_WIDTH accumulator. FINISH negates the 64-bit product if the operand signs differ. Hi=product[63:32], Lo=product[31:0].
- Divide: restoring, one quotient bit per cycle. FINISH negates the quotient if the signs differ and negates the remainder if A<0. Lo=quotient, Hi=remainder.
- Signed 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0. No flag.
- Divide by zero: runs full latency. At FINISH, Hi=A (original value), Lo=0xFFFFFFFF, DivByZero=1 with Done, for both DIV and DIVU.
- MTHI/MTLO: accepted in IDLE only. At that edge Hi (or Lo) ← A. Busy stays 0, Done stays 0.
- Reserved Op with Start: no state change.
- Start while Busy=1: ignored. Upstream must stall; it is not queued.
- Flush: FSM returns to IDLE at that edge, Busy=0 next cycle, Hi/Lo unchanged, no Done.
  - Flush and Start together in IDLE: Flush wins, nothing accepted, MTHI/MTLO write suppressed.
  - Flush in FINISH: Flush wins, no HI/LO write, no Done.
- Rst mid-operation: same as reset; Rst overrides Flush and Start.
- Hi/Lo change only at the FINISH edge, at an MTHI/MTLO edge, or on Rst.

## Timing
- Start accepted at edge N, so Busy=1 from cycle after N.
- RUN occupies edges N+1..N+DATA_WIDTH; FINISH is the cycle after edge N+DATA_WIDTH.
- At edge N+DATA_WIDTH+1: Hi/Lo updated, Done=1 for exactly one cycle, Busy=0. Latency is 33 cycles at DATA_WIDTH=32.
- A new Start is accepted at the first edge where Busy=0. This can be the same cycle Done=1, giving back-to-back operation with no bubble.
- MTHI/MTLO: Hi/Lo visible in the cycle after the accepting edge.
- All outputs registered; no combinational path from inputs to outputs.

## Structure
- Package muldiv_pkg:
  - Op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO).
  - FSM state encoding.
  - DIV0_LO constant 0xFFFFFFFF.
- Sub-module sign_fixup: combinational conditional two's-complement negate of a 2×DATA_WIDTH value. Used for operand magnitude on accept and for result correction in FINISH.
- Top of unit: FSM, iteration counter, accumulator/remainder registers, HI/LO registers.

## Test plan
- MULT A=0xFFFFFFFD, B=7 → after 33 cycles Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; Done high exactly one cycle; Busy high for cycles 1..33.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → Hi=0xFFFFFFFE, Lo=0x00000001; then immediate MULT 0x80000000×0x80000000 → Hi=0x40000000, Lo=0.
- DIV A=0xFFFFFFF9 (−7), B=2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; DIVU A=100, B=7 → Lo=14, Hi=2; DIV 0x80000000/0xFFFFFFFF → Lo=0x80000000, Hi=0.
- DIVU A=5, B=0 → Hi=5, Lo=0xFFFFFFFF, DivByZero and Done pulse together at cycle 33.
- MTHI A=0x12345678 in IDLE → Hi=0x12345678 next cycle, Busy/Done stay 0; Start MTLO during Busy → Lo unchanged after Done.
- DIV started, Flush at cycle 10 → Busy=0 next cycle, Hi/Lo keep prior values, no Done; repeat with Rst at cycle 20 → all outputs 0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
// Holds the operation encodings presented on Op, the FSM state encoding, and
// the LO value written when a divide has a zero divisor.
package muldiv_pkg;

    localparam int DW_DEFAULT = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FINISH
    } state_t;

    localparam logic [DW_DEFAULT-1:0] DIV0_LO = 32'hFFFF_FFFF;

    // MULT/MULTU/DIV/DIVU all have Op[2]=0; the MT* moves and reserved codes do not.
    function automatic logic is_muldiv(input logic [2:0] op);
        return ~op[2];
    endfunction

endpackage

// File: rtl/sign_fixup.sv
// Conditional two's-complement negate.
// Ports:
//   value  : operand to be (optionally) negated
//   neg    : 1 = output -value, 0 = output value unchanged
//   result : corrected value (purely combinational)
// Used both to form operand magnitudes on accept and to restore result signs.
module sign_fixup
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 2 * DW_DEFAULT
) (
    input  logic [WIDTH-1:0] value,
    input  logic             neg,
    output logic [WIDTH-1:0] result
);

    assign result = neg ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Ports:
//   Clk, Rst       : clock, synchronous active-high reset
//   Start, Op      : request and operation (MULT/MULTU/DIV/DIVU/MTHI/MTLO)
//   A, B           : rs / rt operands
//   Flush          : squash the in-flight operation
//   Busy           : operation in flight (stall IF/ID and ID/EX)
//   Done           : one-cycle pulse when HI/LO take a mult/div result
//   DivByZero      : one-cycle pulse with Done for a zero divisor
//   Hi, Lo         : architectural HI/LO
// Multiply is shift-add and divide is restoring, one bit per cycle over a
// 2*DATA_WIDTH accumulator; signs are stripped on accept and restored in FINISH.
module hilo_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = DW_DEFAULT
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Start,
    input  logic [2:0]            Op,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic                  Flush,
    output logic                  Busy,
    output logic                  Done,
    output logic                  DivByZero,
    output logic [DATA_WIDTH-1:0] Hi,
    output logic [DATA_WIDTH-1:0] Lo
);

    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(DW);

    state_t              state, next_state;
    logic [CW-1:0]       cnt_q;
    logic                done_q, dbz_q;
    logic [DW-1:0]       hi_q, lo_q;

    // Operation context captured on accept.
    logic                is_div_q;
    logic                neg_res_q;   // result (product/quotient) must be negated
    logic                neg_rem_q;   // remainder must be negated (dividend < 0)
    logic                div0_q;
    logic [DW-1:0]       a_orig_q;
    logic [DW-1:0]       opnd_q;      // multiplicand or divisor magnitude
    logic [2*DW-1:0]     acc_q;

    // Operand magnitudes; only signed ops strip the sign.
    logic          signed_op, a_neg, b_neg;
    logic [DW-1:0] mag_a, mag_b;

    assign signed_op = ~Op[0];
    assign a_neg     = signed_op & A[DW-1];
    assign b_neg     = signed_op & B[DW-1];

    sign_fixup #(.WIDTH(DW)) u_mag_a (.value(A), .neg(a_neg), .result(mag_a));
    sign_fixup #(.WIDTH(DW)) u_mag_b (.value(B), .neg(b_neg), .result(mag_b));

    logic accept;
    assign accept = (state == ST_IDLE) && Start && !Flush && is_muldiv(Op);

    // Multiply step: add multiplicand into the upper half when the current
    // multiplier bit (acc LSB) is set, then shift the whole accumulator right.
    logic [DW-1:0]   addend;
    logic [DW:0]     sum;
    logic [2*DW-1:0] mult_next;

    assign addend    = acc_q[0] ? opnd_q : '0;
    assign sum       = {1'b0, acc_q[2*DW-1:DW]} + {1'b0, addend};
    assign mult_next = {sum, acc_q[DW-1:1]};

    // Divide step: shift remainder:dividend left one bit and try to subtract
    // the divisor. The shifted remainder is DW+1 bits; when it is >= divisor
    // the difference always fits in DW bits, so a DW-bit subtract suffices.
    logic [DW:0]     shifted;
    logic            fits;
    logic [DW-1:0]   trial;
    logic [2*DW-1:0] div_next;

    assign shifted  = acc_q[2*DW-1:DW-1];
    assign fits     = shifted[DW] | (shifted[DW-1:0] >= opnd_q);
    assign trial    = shifted[DW-1:0] - opnd_q;
    assign div_next = fits ? {trial, acc_q[DW-2:0], 1'b1}
                           : {acc_q[2*DW-2:0], 1'b0};

    // Result sign correction used in FINISH.
    logic [2*DW-1:0] prod_fix;
    logic [DW-1:0]   quo_fix, rem_fix;

    sign_fixup #(.WIDTH(2*DW)) u_fix_prod (.value(acc_q),            .neg(neg_res_q), .result(prod_fix));
    sign_fixup #(.WIDTH(DW))   u_fix_quo  (.value(acc_q[DW-1:0]),    .neg(neg_res_q), .result(quo_fix));
    sign_fixup #(.WIDTH(DW))   u_fix_rem  (.value(acc_q[2*DW-1:DW]), .neg(neg_rem_q), .result(rem_fix));

    // Next-state logic.
    always_comb begin
        // NOTE: next_state gets a default before any branch so no path leaves
        // it unassigned, which would otherwise infer a latch.
        next_state = state;
        case (state)
            ST_IDLE:   if (Start && is_muldiv(Op)) next_state = ST_RUN;
            ST_RUN:    if (cnt_q == CW'(DW - 1))   next_state = ST_FINISH;
            ST_FINISH: next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
        if (Flush) next_state = ST_IDLE;
    end

    // Control state and architectural registers.
    always_ff @(posedge Clk) begin
        // NOTE: all sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (Rst) begin
            state  <= ST_IDLE;
            cnt_q  <= '0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            state  <= next_state;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            cnt_q  <= (state == ST_RUN) ? cnt_q + CW'(1) : '0;

            if (state == ST_IDLE && Start && !Flush) begin
                if (Op == OP_MTHI)      hi_q <= A;
                else if (Op == OP_MTLO) lo_q <= A;
            end

            if (state == ST_FINISH && !Flush) begin
                done_q <= 1'b1;
                if (is_div_q && div0_q) begin
                    hi_q  <= a_orig_q;
                    lo_q  <= DW'(DIV0_LO);
                    dbz_q <= 1'b1;
                end else if (is_div_q) begin
                    hi_q <= rem_fix;
                    lo_q <= quo_fix;
                end else begin
                    {hi_q, lo_q} <= prod_fix;
                end
            end
        end
    end

    // Datapath context. NOTE: these registers have no reset: they are always
    // loaded on accept before being read, and the FSM guards their use.
    always_ff @(posedge Clk) begin
        if (accept) begin
            is_div_q  <= Op[1];
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            div0_q    <= (B == '0);
            a_orig_q  <= A;
            opnd_q    <= Op[1] ? mag_b : mag_a;
            acc_q     <= {{DW{1'b0}}, (Op[1] ? mag_a : mag_b)};
        end else if (state == ST_RUN) begin
            acc_q <= is_div_q ? div_next : mult_next;
        end
    end

    assign Busy      = (state != ST_IDLE);
    assign Done      = done_q;
    assign DivByZero = dbz_q;
    assign Hi        = hi_q;
    assign Lo        = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: directed operations push their
// hand-computed HI/LO/DivByZero into a queue; a monitor pops and compares on
// every Done/DivByZero pulse. Timing, MT* moves, Flush and Rst are checked inline.
module tb_hilo_muldiv_unit;
    import muldiv_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst, Start, Flush;
    logic [2:0]  Op;
    logic [31:0] A, B;
    logic        Busy, Done, DivByZero;
    logic [31:0] Hi, Lo;

    hilo_muldiv_unit #(.DATA_WIDTH(32)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
        .Flush(Flush), .Busy(Busy), .Done(Done), .DivByZero(DivByZero),
        .Hi(Hi), .Lo(Lo)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every result pulse must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge Clk);
            if (Done || DivByZero) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: Done=%0b DivByZero=%0b with nothing outstanding",
                             Done, DivByZero);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("result_hi", Hi, e.hi);
                    check("result_lo", Lo, e.lo);
                    check("div_by_zero", 32'(DivByZero), 32'(e.dbz));
                    check("done_with_result", 32'(Done), 32'd1);
                end
            end
        end
    end

    // Issue one mult/div from the current time, follow it to Done and check
    // Busy/latency. Optionally raise Start for one cycle mid-flight.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                          input int inject_at, input logic [2:0] inj_op, input logic [31:0] inj_a);
        int   lat;
        logic seen;
        exp_q.push_back('{hi: ehi, lo: elo, dbz: edbz});
        Start = 1'b1; Op = op; A = a; B = b;
        @(posedge Clk);
        #1 Start = 1'b0;
        @(negedge Clk);
        check("busy_first_cycle", 32'(Busy), 32'd1);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge Clk);
            lat++;
            if (Done) begin
                seen = 1'b1;
            end else begin
                if (lat == 32) check("busy_finish_cycle", 32'(Busy), 32'd1);
                Start = (lat == inject_at);
                if (lat == inject_at) begin
                    Op = inj_op;
                    A  = inj_a;
                end
            end
        end
        Start = 1'b0;
        check("latency", 32'(lat), 32'd33);
        check("busy_at_done", 32'(Busy), 32'd0);
    endtask

    task automatic done_drop();
        @(negedge Clk);
        check("done_single_pulse", 32'(Done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_cnt;
        Rst = 1'b1; Start = 1'b0; Flush = 1'b0; Op = 3'b000; A = '0; B = '0;
        repeat (3) @(posedge Clk);
        #1 Rst = 1'b0;
        @(negedge Clk);
        check("reset_hi", Hi, 32'h0);
        check("reset_lo", Lo, 32'h0);
        check("reset_busy", 32'(Busy), 32'd0);
        check("reset_done", 32'(Done), 32'd0);
        check("reset_dbz", 32'(DivByZero), 32'd0);

        // -3 * 7 = -21
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, -1, 3'b000, 32'h0);
        done_drop();

        // (2^32-1)^2, then back-to-back signed (-2^31)^2 = 2^62
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, -1, 3'b000, 32'h0);
        run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, -1, 3'b000, 32'h0);
        done_drop();

        // -7 / 2 = -3 rem -1
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, -1, 3'b000, 32'h0);
        // 100 / 7 = 14 rem 2, with an MTLO request raised while Busy
        run_op(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 5, OP_MTLO, 32'hDEAD_BEEF);
        done_drop();
        check("mtlo_while_busy_ignored", Lo, 32'd14);

        // Signed overflow case and divide by zero
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, -1, 3'b000, 32'h0);
        run_op(OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, -1, 3'b000, 32'h0);
        done_drop();

        // MTHI in IDLE
        Start = 1'b1; Op = OP_MTHI; A = 32'h1234_5678;
        @(posedge Clk);
        #1 Start = 1'b0;
        @(negedge Clk);
        check("mthi_hi", Hi, 32'h1234_5678);
        check("mthi_lo_kept", Lo, 32'hFFFF_FFFF);
        check("mthi_busy", 32'(Busy), 32'd0);
        check("mthi_done", 32'(Done), 32'd0);

        // Flush with MTLO in the same cycle: write suppressed
        Start = 1'b1; Flush = 1'b1; Op = OP_MTLO; A = 32'hAAAA_5555;
        @(posedge Clk);
        #1 Start = 1'b0; Flush = 1'b0;
        @(negedge Clk);
        check("flush_mtlo_lo", Lo, 32'hFFFF_FFFF);

        // Flush with MULT in the same cycle: nothing accepted
        Start = 1'b1; Flush = 1'b1; Op = OP_MULT; A = 32'd3; B = 32'd3;
        @(posedge Clk);
        #1 Start = 1'b0; Flush = 1'b0;
        @(negedge Clk);
        check("flush_start_busy", 32'(Busy), 32'd0);

        // Reserved op
        Start = 1'b1; Op = 3'b110; A = 32'h5555_AAAA;
        @(posedge Clk);
        #1 Start = 1'b0;
        @(negedge Clk);
        check("reserved_busy", 32'(Busy), 32'd0);
        check("reserved_hi", Hi, 32'h1234_5678);
        check("reserved_lo", Lo, 32'hFFFF_FFFF);

        // DIV flushed at cycle 10
        Start = 1'b1; Op = OP_DIV; A = 32'd100; B = 32'd7;
        @(posedge Clk);
        #1 Start = 1'b0;
        repeat (10) @(negedge Clk);
        Flush = 1'b1;
        @(negedge Clk);
        Flush = 1'b0;
        check("flush_busy", 32'(Busy), 32'd0);
        check("flush_hi_kept", Hi, 32'h1234_5678);
        check("flush_lo_kept", Lo, 32'hFFFF_FFFF);
        done_cnt = 0;
        repeat (40) begin
            @(negedge Clk);
            if (Done) done_cnt++;
        end
        check("flush_no_done", 32'(done_cnt), 32'd0);

        // DIV interrupted by Rst at cycle 20
        Start = 1'b1; Op = OP_DIV; A = 32'd100; B = 32'd7;
        @(posedge Clk);
        #1 Start = 1'b0;
        repeat (20) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        check("rst_mid_hi", Hi, 32'h0);
        check("rst_mid_lo", Lo, 32'h0);
        check("rst_mid_busy", 32'(Busy), 32'd0);
        check("rst_mid_done", 32'(Done), 32'd0);
        check("rst_mid_dbz", 32'(DivByZero), 32'd0);
        repeat (40) @(negedge Clk);

        check("outstanding_results", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
